// File: rtl/asr8_seq_if.sv
// Request/result bundle for the multi-cycle ASR8 sequencer.
// The controller drives through the master modport and the sequencer answers through the slave modport.
interface asr8_seq_if;
  logic       start;
  logic [7:0] d_in;
  logic [3:0] shamt;
  logic       busy;
  logic       done;
  logic [7:0] d_out;

  modport master (
    output start, d_in, shamt,
    input  busy, done, d_out
  );

  modport slave (
    input  start, d_in, shamt,
    output busy, done, d_out
  );
endinterface

// File: rtl/asr8_seq.sv
// Arithmetic shift right of an 8-bit signed operand by 0..15.
// One 2-bit ASR8 stage is reused, shifting by up to 3 per pass.
module asr8_seq (
  input  logic      clk,
  input  logic      reset,
  asr8_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_nx_s;
  logic [7:0] acc_r;
  logic [7:0] acc_nx_s;
  logic [3:0] rem_r;
  logic [3:0] rem_nx_s;
  logic [7:0] d_out_r;
  logic [7:0] d_out_nx_s;
  logic       busy_r;
  logic       done_r;
  logic [1:0] step_s;
  logic [7:0] shifted_s;

  function automatic logic [7:0] asr8(input logic [7:0] a, input logic [1:0] s);
    logic [7:0] r;
    case (s)
      2'd0:    r = a;
      2'd1:    r = {a[7], a[7:1]};
      2'd2:    r = {{2{a[7]}}, a[7:2]};
      2'd3:    r = {{3{a[7]}}, a[7:3]};
      default: r = a;
    endcase
    return r;
  endfunction

  // Per-pass shift amount, limited to what the ASR8 stage can do in one go.
  always_comb begin
    step_s = 2'd0;
    if (rem_r >= 4'd3) begin
      step_s = 2'd3;
    end else begin
      step_s = rem_r[1:0];
    end
  end

  assign shifted_s = asr8(acc_r, step_s);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and datapath update selection.
  always_comb begin
    state_nx_s = state_r;
    acc_nx_s   = acc_r;
    rem_nx_s   = rem_r;
    d_out_nx_s = d_out_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (bus.shamt != 4'd0) begin
            acc_nx_s   = bus.d_in;
            rem_nx_s   = bus.shamt;
            state_nx_s = SHIFT;
          end else begin
            d_out_nx_s = bus.d_in;
            state_nx_s = DONE;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        acc_nx_s = shifted_s;
        rem_nx_s = rem_r - {2'b00, step_s};
        if (rem_r == {2'b00, step_s}) begin
          d_out_nx_s = shifted_s;
          state_nx_s = DONE;
        end else begin
          state_nx_s = SHIFT;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Datapath registers; busy/done are registered from the next state so they track state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r   <= 8'h00;
      rem_r   <= 4'd0;
      d_out_r <= 8'h00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      acc_r   <= acc_nx_s;
      rem_r   <= rem_nx_s;
      d_out_r <= d_out_nx_s;
      busy_r  <= (state_nx_s != IDLE);
      done_r  <= (state_nx_s == DONE);
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.d_out = d_out_r;

endmodule

// File: tb/tb_asr8_seq.sv
// Self-checking bench for asr8_seq: directed cases, a full sweep, random operations,
// protocol (busy/DONE start ignore) and reset-abort scenarios against an arithmetic reference.
module tb_asr8_seq;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  asr8_seq_if bus ();

  asr8_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: floor division of the signed value by 2^s, wrapped to 8 bits.
  function automatic logic [7:0] ref_asr(input logic [7:0] d, input int s);
    int v;
    int p;
    int q;
    v = d[7] ? (int'(d) - 256) : int'(d);
    p = 1 << s;
    q = v / p;
    if (v < 0 && q * p != v) q = q - 1;
    return q[7:0];
  endfunction

  function automatic int ref_lat(input int s);
    return (s + 2) / 3;
  endfunction

  // Drives one request and observes it up to the cycle after done.
  task automatic run_op(input logic [7:0] d, input logic [3:0] s,
                        output int lat, output logic [7:0] res, output int busy_cnt,
                        output logic tail_ok, output logic stable);
    logic [7:0] prev;
    @(negedge clk);
    prev      = bus.d_out;
    bus.start = 1'b1;
    bus.d_in  = d;
    bus.shamt = s;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.d_in  = 8'($urandom);
    bus.shamt = 4'($urandom);
    stable    = 1'b1;
    lat       = 0;
    busy_cnt  = bus.busy ? 1 : 0;
    while (!bus.done && lat < 20) begin
      if (bus.d_out !== prev) stable = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) busy_cnt++;
    end
    res = bus.d_out;
    @(posedge clk);
    #1;
    tail_ok = !bus.done && !bus.busy;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.d_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b d_out=%h required 0 0 00", bus.busy, bus.done, bus.d_out);
    end
  endtask

  task automatic test_directed();
    logic [7:0] dv [4];
    int         sv [4];
    logic [7:0] ev [4];
    int         lat;
    int         bc;
    logic [7:0] res;
    logic       tail;
    logic       stab;
    dv[0] = 8'hAD; sv[0] = 5;  ev[0] = 8'hFD;
    dv[1] = 8'hAD; sv[1] = 0;  ev[1] = 8'hAD;
    dv[2] = 8'h80; sv[2] = 7;  ev[2] = 8'hFF;
    dv[3] = 8'h7F; sv[3] = 15; ev[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      run_op(dv[i], 4'(sv[i]), lat, res, bc, tail, stab);
      checks++;
      if (res !== ev[i]) begin
        failures++;
        $display("FAIL directed_result d_in=%h shamt=%0d: got %h required %h", dv[i], sv[i], res, ev[i]);
      end
      checks++;
      if (lat != ref_lat(sv[i]) || bc != ref_lat(sv[i]) + 1) begin
        failures++;
        $display("FAIL directed_timing shamt=%0d: latency %0d busy %0d required %0d %0d",
                 sv[i], lat, bc, ref_lat(sv[i]), ref_lat(sv[i]) + 1);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] dv [6];
    int         lat;
    int         bc;
    logic [7:0] res;
    logic       tail;
    logic       stab;
    dv[0] = 8'h00; dv[1] = 8'h01; dv[2] = 8'h7F; dv[3] = 8'h80; dv[4] = 8'hAD; dv[5] = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      for (int s = 0; s < 16; s++) begin
        run_op(dv[i], 4'(s), lat, res, bc, tail, stab);
        checks++;
        if (res !== ref_asr(dv[i], s) || lat != ref_lat(s) || !tail || !stab) begin
          failures++;
          $display("FAIL sweep d_in=%h shamt=%0d: got %h lat %0d tail %b stable %b required %h lat %0d tail 1 stable 1",
                   dv[i], s, res, lat, tail, stab, ref_asr(dv[i], s), ref_lat(s));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int         s;
    int         lat;
    int         bc;
    logic [7:0] res;
    logic       tail;
    logic       stab;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      s = int'($urandom_range(15, 0));
      run_op(d, 4'(s), lat, res, bc, tail, stab);
      checks++;
      if (res !== ref_asr(d, s) || lat != ref_lat(s) || bc != ref_lat(s) + 1 || !tail || !stab) begin
        failures++;
        $display("FAIL random d_in=%h shamt=%0d: got %h lat %0d busy %0d required %h lat %0d busy %0d",
                 d, s, res, lat, bc, ref_asr(d, s), ref_lat(s), ref_lat(s) + 1);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.d_in = 8'hAD; bus.shamt = 4'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.d_in = 8'h01; bus.shamt = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bus.d_out !== 8'hFF || cyc >= 20) begin
      failures++;
      $display("FAIL busy_ignore: d_out=%h required ff", bus.d_out);
    end
    bus.start = 1'b1; bus.d_in = 8'h01; bus.shamt = 4'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.d_out !== 8'hFF) begin
      failures++;
      $display("FAIL done_cycle_ignore: busy=%b d_out=%h required 0 ff", bus.busy, bus.d_out);
    end
  endtask

  task automatic test_reset_abort();
    logic seen_done;
    @(negedge clk);
    bus.start = 1'b1; bus.d_in = 8'hAD; bus.shamt = 4'd12;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.d_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_abort: busy=%b done=%b d_out=%h required 0 0 00", bus.busy, bus.done, bus.d_out);
    end
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: activity after abort=%b required 0", seen_done);
    end
  endtask

  task automatic test_reset_start_high();
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1; bus.d_in = 8'h40; bus.shamt = 4'd1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL start_after_reset_accept: busy=%b required 1", bus.busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.d_out !== 8'h20) begin
      failures++;
      $display("FAIL start_after_reset_result: done=%b d_out=%h required 1 20", bus.done, bus.d_out);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.d_in  = 8'h00;
    bus.shamt = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_directed();
    test_sweep();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    test_reset_start_high();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/asr8_seq.md
# asr8_seq

Multi-cycle arithmetic-shift-right sequencer for 8-bit signed data. It extends the 2-bit-shamt ASR8 datapath to shift amounts 0..15 by reusing one internal ASR8 instance for as many passes as the requested amount needs. Each pass shifts by at most 3. The block sits between a requesting controller and the shifter datapath and exposes a start/busy/done handshake.

## Interface
- No parameters. Data width is fixed at 8 and the shift-amount width at 4.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- d_in  input  8  signed operand; latched when start is accepted.
- shamt  input  4  total shift amount 0..15; latched when start is accepted.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion strobe.
- d_out  output  8  registered result; holds the last completed result.

## Operation
- One internal ASR8 instance: d_in = acc, shamt = step, d_out = the next value of acc.
- Registers:
  - acc[7:0] holds the working value.
  - rem[3:0] holds the remaining shift amount.
  - d_out[7:0] is the output register.
  - state holds one of {IDLE, SHIFT, DONE}.
- Step rule: step = (rem >= 3) ? 2'd3 : rem[1:0].
- IDLE:
  - If start=1 and shamt != 0: acc <= d_in, rem <= shamt, go to SHIFT.
  - If start=1 and shamt = 0: d_out <= d_in, go to DONE.
  - If start=0: stay in IDLE.
- SHIFT, on every cycle:
  - acc <= ASR8(acc, step), rem <= rem - step.
  - If rem == step: d_out <= ASR8(acc, step), go to DONE. Otherwise stay in SHIFT.
- DONE: go to IDLE unconditionally.
- Shift semantics: arithmetic, so bit 7 is replicated. The final result equals $signed(d_in) >>> shamt.
  - For shamt >= 7 the result is 8'hFF if d_in[7]=1, else 8'h00.
- Number of SHIFT cycles: n = ceil(shamt/3), which ranges over 0..5.
- start while busy=1: ignored. The operand is not latched and there is no queueing.
- acc, rem and d_out change only as listed above. d_out is stable in IDLE and SHIFT, and its value persists across operations.

## Timing
- Reset values: state=IDLE, acc=0, rem=0, d_out=8'h00, busy=0, done=0.
- busy and done are decoded from the registered state and are glitch-free:
  - busy = (state != IDLE).
  - done = (state == DONE).
- Start accepted at rising edge k:
  - SHIFT occupies edges k+1..k+n.
  - d_out is updated at edge k+n.
  - done is high for exactly one cycle, from edge k+n to edge k+n+1.
  - busy is high from edge k to edge k+n+1.
- shamt=0: d_out is updated at edge k; done and busy are high for the single cycle after edge k.
- Back-to-back operation: the earliest next accept is the edge at which DONE returns to IDLE plus one. start high in the DONE cycle is ignored.
- Reset asserted mid-operation: aborts immediately, and every register, including d_out, returns to its reset value. No done pulse is issued for the aborted request.
- Reset released with start already high: the start is accepted at the first rising edge after reset deasserts.

## Test plan
- d_in=8'hAD, shamt=5:
  - step sequence 3 then 2; acc goes 8'hF5 then 8'hFD.
  - d_out=8'hFD, done high 2 cycles after the accept edge; busy high for 3 cycles.
- d_in=8'hAD, shamt=0: d_out=8'hAD, done in the cycle right after the accept edge, busy high for 1 cycle.
- d_in=8'h80, shamt=7: steps 3,3,1 give d_out=8'hFF.
- d_in=8'h7F, shamt=15: 5 SHIFT cycles give d_out=8'h00.
- Sweep: for all d_in in {8'h00, 8'h01, 8'h7F, 8'h80, 8'hAD, 8'hFF} and shamt 0..15:
  - d_out == $signed(d_in) >>> shamt.
  - done width is exactly 1 cycle.
  - latency = ceil(shamt/3).
- Protocol and reset:
  - Start d_in=8'hAD, shamt=9. Pulse start with d_in=8'h01 while busy: that start is ignored and d_out=8'hFF.
  - Start again with shamt=12. Assert reset during the 2nd SHIFT cycle: d_out=8'h00, busy=0, and no done is issued.
